// File: rtl/omsp_spm_alloc_pkg.sv
// ---------------------------------------------------------------------------
// omsp_spm_alloc_pkg
// Shared definitions for the Sancus protected-module allocator:
//   - default slot count
//   - request operation codes and response status codes
//   - allocator FSM state encoding
//   - helper to size the slot index register
// ---------------------------------------------------------------------------
package omsp_spm_alloc_pkg;

  localparam int NB_SLOTS_DEF = 4;

  localparam logic [1:0] OP_CREATE   = 2'd0;
  localparam logic [1:0] OP_DESTROY  = 2'd1;
  localparam logic [1:0] OP_QUERY    = 2'd2;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_BAD_LAYOUT = 2'd1;
  localparam logic [1:0] ST_OVERLAP    = 2'd2;
  localparam logic [1:0] ST_RESOURCE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SCAN  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // A single-slot table still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/omsp_spm_slot.sv
// ---------------------------------------------------------------------------
// omsp_spm_slot
// Registers of one protected-module slot plus the combinational tests the
// allocator needs while scanning the table.
// Ports:
//   mclk, puc_rst          clock, async active-high reset
//   i_wr, i_clr            load the slot with i_wr_id + bounds / wipe it
//   i_wr_id                ID stored on i_wr
//   i_pub_*, i_sec_*       candidate ranges (write data and overlap operand)
//   i_addr                 address tested for containment
//   i_match_id             ID compared against the stored ID
//   o_enabled, o_id        stored state
//   o_overlap              candidate ranges hit this (enabled) slot
//   o_contains             i_addr lies inside this (enabled) slot
//   o_id_match             this (enabled) slot holds i_match_id
// ---------------------------------------------------------------------------
module omsp_spm_slot
  import omsp_spm_alloc_pkg::*;
#(
  parameter int ID_W = 16,
  parameter int AW   = 16
) (
  input  logic            mclk,
  input  logic            puc_rst,
  input  logic            i_wr,
  input  logic            i_clr,
  input  logic [ID_W-1:0] i_wr_id,
  input  logic [AW-1:0]   i_pub_start,
  input  logic [AW-1:0]   i_pub_end,
  input  logic [AW-1:0]   i_sec_start,
  input  logic [AW-1:0]   i_sec_end,
  input  logic [AW-1:0]   i_addr,
  input  logic [ID_W-1:0] i_match_id,
  output logic            o_enabled,
  output logic [ID_W-1:0] o_id,
  output logic            o_overlap,
  output logic            o_contains,
  output logic            o_id_match
);

  logic            r_enabled;
  logic [ID_W-1:0] r_id;
  logic [AW-1:0]   r_pub_start, r_pub_end, r_sec_start, r_sec_end;

  // Half-open ranges [s,e) intersect iff each starts before the other ends.
  function automatic logic rng_ovl(input logic [AW-1:0] a_s, input logic [AW-1:0] a_e,
                                   input logic [AW-1:0] b_s, input logic [AW-1:0] b_e);
    return (a_s < b_e) && (b_s < a_e);
  endfunction

  // Slot storage: a write loads a fresh module, a clear wipes bounds and ID.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_enabled   <= 1'b0;
      r_id        <= '0;
      r_pub_start <= '0;
      r_pub_end   <= '0;
      r_sec_start <= '0;
      r_sec_end   <= '0;
    end else if (i_wr) begin
      r_enabled   <= 1'b1;
      r_id        <= i_wr_id;
      r_pub_start <= i_pub_start;
      r_pub_end   <= i_pub_end;
      r_sec_start <= i_sec_start;
      r_sec_end   <= i_sec_end;
    end else if (i_clr) begin
      r_enabled   <= 1'b0;
      r_id        <= '0;
      r_pub_start <= '0;
      r_pub_end   <= '0;
      r_sec_start <= '0;
      r_sec_end   <= '0;
    end
  end

  assign o_enabled  = r_enabled;
  assign o_id       = r_id;
  assign o_overlap  = r_enabled &&
                      (rng_ovl(i_pub_start, i_pub_end, r_pub_start, r_pub_end) ||
                       rng_ovl(i_pub_start, i_pub_end, r_sec_start, r_sec_end) ||
                       rng_ovl(i_sec_start, i_sec_end, r_pub_start, r_pub_end) ||
                       rng_ovl(i_sec_start, i_sec_end, r_sec_start, r_sec_end));
  assign o_contains = r_enabled &&
                      (((r_pub_start <= i_addr) && (i_addr < r_pub_end)) ||
                       ((r_sec_start <= i_addr) && (i_addr < r_sec_end)));
  assign o_id_match = r_enabled && (r_id == i_match_id);

endmodule

// File: rtl/omsp_spm_alloc.sv
// ---------------------------------------------------------------------------
// omsp_spm_alloc
// Protected-module allocator: serialises create/destroy/query requests over
// a table of NB_SLOTS slots, checking one slot per cycle, and tracks the
// previous distinct PC for entry-point checks.
// Ports:
//   mclk, puc_rst              clock, async active-high reset
//   i_req_valid / o_req_ready  request handshake (ready only in IDLE)
//   i_req_op                   00 create, 01 destroy, 10 query, 11 reserved
//   i_r12..i_r15               create bounds; i_r12 is the query address
//   i_req_id                   destroy target ID
//   o_rsp_valid                one-cycle response pulse
//   o_rsp_status, o_rsp_id     response code and ID, held until next response
//   o_slot_enabled             per-slot enabled flags
//   o_id_exhausted             sticky, set once the all-ones ID is issued
//   i_pc / o_prev_pc           current PC / last PC that differed from it
// ---------------------------------------------------------------------------
module omsp_spm_alloc
  import omsp_spm_alloc_pkg::*;
#(
  parameter int NB_SLOTS = NB_SLOTS_DEF,
  parameter int ID_W     = 16,
  parameter int AW       = 16
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [1:0]          i_req_op,
  input  logic [AW-1:0]       i_r12,
  input  logic [AW-1:0]       i_r13,
  input  logic [AW-1:0]       i_r14,
  input  logic [AW-1:0]       i_r15,
  input  logic [ID_W-1:0]     i_req_id,
  output logic                o_rsp_valid,
  output logic [1:0]          o_rsp_status,
  output logic [ID_W-1:0]     o_rsp_id,
  output logic [NB_SLOTS-1:0] o_slot_enabled,
  output logic                o_id_exhausted,
  input  logic [AW-1:0]       i_pc,
  output logic [AW-1:0]       o_prev_pc
);

  localparam int               IDX_W    = idx_width(NB_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SLOTS - 1);

  state_e r_state, w_next_state;

  logic [1:0]       r_op;
  logic [AW-1:0]    r_r12, r_r13, r_r14, r_r15;
  logic [ID_W-1:0]  r_req_id;
  logic             r_reject;
  logic [1:0]       r_rej_status;
  logic [IDX_W-1:0] r_idx;
  logic             r_overlap;
  logic             r_free_found;
  logic [IDX_W-1:0] r_free_idx;
  logic             r_found;
  logic [IDX_W-1:0] r_found_idx;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_status;
  logic [ID_W-1:0]  r_rsp_id;
  logic [ID_W-1:0]  r_next_id;
  logic             r_id_exhausted;
  logic [AW-1:0]    r_cur_pc, r_prev_pc;

  logic [NB_SLOTS-1:0] w_slot_en, w_slot_ovl, w_slot_cont, w_slot_match;
  logic [NB_SLOTS-1:0] w_slot_wr, w_slot_clr;
  logic [ID_W-1:0]     w_slot_id [NB_SLOTS];

  logic       w_bad_layout, w_check_reject, w_create_ok, w_destroy_ok;
  logic [1:0] w_check_status;

  for (genvar g = 0; g < NB_SLOTS; g++) begin : g_slot
    omsp_spm_slot #(.ID_W(ID_W), .AW(AW)) u_slot (
      .mclk        (mclk),
      .puc_rst     (puc_rst),
      .i_wr        (w_slot_wr[g]),
      .i_clr       (w_slot_clr[g]),
      .i_wr_id     (r_next_id),
      .i_pub_start (r_r12),
      .i_pub_end   (r_r13),
      .i_sec_start (r_r14),
      .i_sec_end   (r_r15),
      .i_addr      (r_r12),
      .i_match_id  (r_req_id),
      .o_enabled   (w_slot_en[g]),
      .o_id        (w_slot_id[g]),
      .o_overlap   (w_slot_ovl[g]),
      .o_contains  (w_slot_cont[g]),
      .o_id_match  (w_slot_match[g])
    );
  end

  // Empty ranges or public/secret sections that share any address.
  assign w_bad_layout = (r_r12 >= r_r13) || (r_r14 >= r_r15) ||
                        ((r_r12 < r_r15) && (r_r14 < r_r13));

  // Requests that can be answered without walking the table.
  always_comb begin
    w_check_reject = 1'b0;
    w_check_status = ST_OK;
    case (r_op)
      OP_CREATE: begin
        if (w_bad_layout) begin
          w_check_reject = 1'b1;
          w_check_status = ST_BAD_LAYOUT;
        end else if (r_id_exhausted) begin
          w_check_reject = 1'b1;
          w_check_status = ST_RESOURCE;
        end
      end
      OP_DESTROY: begin
        if (r_req_id == '0) begin
          w_check_reject = 1'b1;
          w_check_status = ST_RESOURCE;
        end
      end
      OP_QUERY: ;
      default: begin
        w_check_reject = 1'b1;
        w_check_status = ST_RESOURCE;
      end
    endcase
  end

  assign w_create_ok  = (r_op == OP_CREATE) && !r_reject && !r_overlap && r_free_found;
  assign w_destroy_ok = (r_op == OP_DESTROY) && !r_reject && r_found;

  // State register.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state plus the slot write/clear strobes, which fire on the RESP edge.
  always_comb begin
    w_next_state = r_state;
    w_slot_wr    = '0;
    w_slot_clr   = '0;
    case (r_state)
      S_IDLE:  if (i_req_valid) w_next_state = S_CHECK;
      S_CHECK: w_next_state = w_check_reject ? S_RESP : S_SCAN;
      S_SCAN:  if (r_idx == LAST_IDX) w_next_state = S_RESP;
      S_RESP: begin
        w_next_state = S_IDLE;
        if (w_create_ok)  w_slot_wr[r_free_idx]   = 1'b1;
        if (w_destroy_ok) w_slot_clr[r_found_idx] = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture, per-slot scan bookkeeping and response/ID resolution.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_op           <= '0;
      r_r12          <= '0;
      r_r13          <= '0;
      r_r14          <= '0;
      r_r15          <= '0;
      r_req_id       <= '0;
      r_reject       <= 1'b0;
      r_rej_status   <= ST_OK;
      r_idx          <= '0;
      r_overlap      <= 1'b0;
      r_free_found   <= 1'b0;
      r_free_idx     <= '0;
      r_found        <= 1'b0;
      r_found_idx    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_status   <= ST_OK;
      r_rsp_id       <= '0;
      r_next_id      <= ID_W'(1);
      r_id_exhausted <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op     <= i_req_op;
            r_r12    <= i_r12;
            r_r13    <= i_r13;
            r_r14    <= i_r14;
            r_r15    <= i_r15;
            r_req_id <= i_req_id;
          end
        end
        S_CHECK: begin
          r_reject     <= w_check_reject;
          r_rej_status <= w_check_status;
          r_idx        <= '0;
          r_overlap    <= 1'b0;
          r_free_found <= 1'b0;
          r_free_idx   <= '0;
          r_found      <= 1'b0;
          r_found_idx  <= '0;
        end
        S_SCAN: begin
          r_idx <= r_idx + 1'b1;
          case (r_op)
            OP_CREATE: begin
              if (w_slot_en[r_idx]) begin
                if (w_slot_ovl[r_idx]) r_overlap <= 1'b1;
              end else if (!r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
              end
            end
            OP_DESTROY: begin
              if (!r_found && w_slot_match[r_idx]) begin
                r_found     <= 1'b1;
                r_found_idx <= r_idx;
              end
            end
            OP_QUERY: begin
              if (!r_found && w_slot_cont[r_idx]) begin
                r_found     <= 1'b1;
                r_found_idx <= r_idx;
              end
            end
            default: ;
          endcase
        end
        S_RESP: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= '0;
          r_rsp_status <= ST_RESOURCE;
          if (r_reject) begin
            r_rsp_status <= r_rej_status;
          end else begin
            case (r_op)
              OP_CREATE: begin
                if (r_overlap) begin
                  r_rsp_status <= ST_OVERLAP;
                end else if (r_free_found) begin
                  r_rsp_status <= ST_OK;
                  r_rsp_id     <= r_next_id;
                  // The all-ones ID is the last one ever handed out.
                  if (r_next_id == '1) r_id_exhausted <= 1'b1;
                  else                 r_next_id      <= r_next_id + 1'b1;
                end
              end
              OP_DESTROY: begin
                if (r_found) begin
                  r_rsp_status <= ST_OK;
                  r_rsp_id     <= r_req_id;
                end
              end
              OP_QUERY: begin
                if (r_found) begin
                  r_rsp_status <= ST_OK;
                  r_rsp_id     <= w_slot_id[r_found_idx];
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Previous-distinct-PC tracker for the entry-point checks.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_cur_pc  <= '0;
      r_prev_pc <= '0;
    end else if (i_pc != r_cur_pc) begin
      r_prev_pc <= r_cur_pc;
      r_cur_pc  <= i_pc;
    end
  end

  assign o_req_ready    = (r_state == S_IDLE);
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_status   = r_rsp_status;
  assign o_rsp_id       = r_rsp_id;
  assign o_slot_enabled = w_slot_en;
  assign o_id_exhausted = r_id_exhausted;
  assign o_prev_pc      = r_prev_pc;

endmodule

// File: tb/tb_omsp_spm_alloc.sv
// ---------------------------------------------------------------------------
// tb_omsp_spm_alloc
// Scoreboard bench for the allocator: instance A uses default parameters,
// instance B uses ID_W = 2 to reach ID exhaustion quickly.
// ---------------------------------------------------------------------------
module tb_omsp_spm_alloc;

   localparam logic [1:0] CR = 2'd0, DE = 2'd1, QU = 2'd2, RSV = 2'd3;
   localparam logic [1:0] OK = 2'd0, BAD = 2'd1, OVL = 2'd2, RES = 2'd3;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        reqValidA, reqValidB;
   logic [1:0]  reqOp;
   logic [15:0] r12, r13, r14, r15, reqId, pc;

   logic        reqReadyA, rspValidA, idExhA;
   logic [1:0]  rspStatusA;
   logic [15:0] rspIdA, prevPcA;
   logic [3:0]  slotEnA;

   logic        reqReadyB, rspValidB, idExhB;
   logic [1:0]  rspStatusB, rspIdB;
   logic [15:0] prevPcB;
   logic [3:0]  slotEnB;

   typedef struct {
      logic [1:0]  status;
      logic [15:0] id;
      int          lat;
      logic [3:0]  slots;
      bit          timeout;
   } rsp_t;

   rsp_t sb[$];
   rsp_t obs[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 mclk = ~mclk;

   omsp_spm_alloc #(.NB_SLOTS(4), .ID_W(16), .AW(16)) dutA (
      .mclk(mclk), .puc_rst(puc_rst),
      .i_req_valid(reqValidA), .o_req_ready(reqReadyA), .i_req_op(reqOp),
      .i_r12(r12), .i_r13(r13), .i_r14(r14), .i_r15(r15), .i_req_id(reqId),
      .o_rsp_valid(rspValidA), .o_rsp_status(rspStatusA), .o_rsp_id(rspIdA),
      .o_slot_enabled(slotEnA), .o_id_exhausted(idExhA),
      .i_pc(pc), .o_prev_pc(prevPcA)
   );

   omsp_spm_alloc #(.NB_SLOTS(4), .ID_W(2), .AW(16)) dutB (
      .mclk(mclk), .puc_rst(puc_rst),
      .i_req_valid(reqValidB), .o_req_ready(reqReadyB), .i_req_op(reqOp),
      .i_r12(r12), .i_r13(r13), .i_r14(r14), .i_r15(r15), .i_req_id(reqId[1:0]),
      .o_rsp_valid(rspValidB), .o_rsp_status(rspStatusB), .o_rsp_id(rspIdB),
      .o_slot_enabled(slotEnB), .o_id_exhausted(idExhB),
      .i_pc(pc), .o_prev_pc(prevPcB)
   );

   // Pushes the expected response, issues one request and records what came back.
   task automatic applyStimulus(input bit useB, input logic [1:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d,
                                input logic [15:0] id, input logic [1:0] expStatus,
                                input logic [15:0] expId, input int expLat,
                                input logic [3:0] expSlots);
      rsp_t e;
      rsp_t o;
      int   waitCnt;
      e.status = expStatus; e.id = expId; e.lat = expLat; e.slots = expSlots; e.timeout = 1'b0;
      sb.push_back(e);
      @(negedge mclk);
      waitCnt = 0;
      while (!(useB ? reqReadyB : reqReadyA) && waitCnt < 50) begin
         @(negedge mclk);
         waitCnt++;
      end
      reqOp = op; r12 = a; r13 = b; r14 = c; r15 = d; reqId = id;
      if (useB) reqValidB = 1'b1;
      else      reqValidA = 1'b1;
      @(posedge mclk);
      #1;
      reqValidA = 1'b0;
      reqValidB = 1'b0;
      o.lat = 0; o.timeout = 1'b1; o.status = 2'd0; o.id = 16'd0; o.slots = 4'd0;
      while (o.lat < 50) begin
         @(posedge mclk);
         #1;
         o.lat++;
         if (useB ? rspValidB : rspValidA) begin
            o.timeout = 1'b0;
            break;
         end
      end
      o.status = useB ? rspStatusB : rspStatusA;
      o.id     = useB ? {14'd0, rspIdB} : rspIdA;
      o.slots  = useB ? slotEnB : slotEnA;
      obs.push_back(o);
   endtask

   task automatic test_reset;
      puc_rst = 1'b1;
      reqValidA = 1'b0; reqValidB = 1'b0; reqOp = 2'd0;
      r12 = '0; r13 = '0; r14 = '0; r15 = '0; reqId = '0; pc = '0;
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      puc_rst = 1'b0;
      @(posedge mclk);
      #1;
      testsRun++;
      if (reqReadyA !== 1'b1 || rspValidA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_handshake: ready=%b valid=%b, want 1 0", reqReadyA, rspValidA);
      end
      testsRun++;
      if (rspStatusA !== 2'd0 || rspIdA !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_rsp: status=%0d id=%h, want 0 0", rspStatusA, rspIdA);
      end
      testsRun++;
      if (slotEnA !== 4'b0000 || idExhA !== 1'b0 || prevPcA !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_table: slots=%b exh=%b prev=%h, want 0000 0 0000", slotEnA, idExhA, prevPcA);
      end
      testsRun++;
      if (reqReadyB !== 1'b1 || slotEnB !== 4'b0000 || idExhB !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_b: ready=%b slots=%b exh=%b, want 1 0000 0", reqReadyB, slotEnB, idExhB);
      end
   endtask

   task automatic test_create;
      rsp_t e, o;
      int   n = 0;
      applyStimulus(0, CR, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, OK, 16'd1, 6, 4'b0001);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL create[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_reject;
      rsp_t e, o;
      int   n = 0;
      applyStimulus(0, CR, 16'h10F0, 16'h1200, 16'h3000, 16'h3100, 0, OVL, 16'd0, 6, 4'b0001);
      applyStimulus(0, CR, 16'h6000, 16'h6100, 16'h20FF, 16'h2200, 0, OVL, 16'd0, 6, 4'b0001);
      applyStimulus(0, CR, 16'h4000, 16'h4000, 16'h5000, 16'h5100, 0, BAD, 16'd0, 2, 4'b0001);
      applyStimulus(0, CR, 16'h4000, 16'h4100, 16'h40F0, 16'h4200, 0, BAD, 16'd0, 2, 4'b0001);
      applyStimulus(0, CR, 16'h4000, 16'h4100, 16'h5100, 16'h5000, 0, BAD, 16'd0, 2, 4'b0001);
      applyStimulus(0, RSV, 16'h4000, 16'h4100, 16'h5000, 16'h5100, 0, RES, 16'd0, 2, 4'b0001);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL reject[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_fill;
      rsp_t e, o;
      int   n = 0;
      // Touching half-open ranges must not count as overlap.
      applyStimulus(0, CR, 16'h1100, 16'h1200, 16'h2100, 16'h2200, 0, OK, 16'd2, 6, 4'b0011);
      applyStimulus(0, CR, 16'h4000, 16'h4100, 16'h4200, 16'h4300, 0, OK, 16'd3, 6, 4'b0111);
      applyStimulus(0, CR, 16'h5000, 16'h5100, 16'h5200, 16'h5300, 0, OK, 16'd4, 6, 4'b1111);
      applyStimulus(0, CR, 16'h6000, 16'h6100, 16'h6200, 16'h6300, 0, RES, 16'd0, 6, 4'b1111);
      applyStimulus(0, DE, 0, 0, 0, 0, 16'd2, OK, 16'd2, 6, 4'b1101);
      applyStimulus(0, CR, 16'h7000, 16'h7100, 16'h7200, 16'h7300, 0, OK, 16'd5, 6, 4'b1111);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL fill[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_query;
      rsp_t e, o;
      int   n = 0;
      applyStimulus(0, QU, 16'h2050, 0, 0, 0, 0, OK, 16'd1, 6, 4'b1111);
      applyStimulus(0, QU, 16'h2100, 0, 0, 0, 0, RES, 16'd0, 6, 4'b1111);
      applyStimulus(0, QU, 16'h1000, 0, 0, 0, 0, OK, 16'd1, 6, 4'b1111);
      applyStimulus(0, QU, 16'h10FF, 0, 0, 0, 0, OK, 16'd1, 6, 4'b1111);
      applyStimulus(0, QU, 16'h7250, 0, 0, 0, 0, OK, 16'd5, 6, 4'b1111);
      applyStimulus(0, QU, 16'h5000, 0, 0, 0, 0, OK, 16'd4, 6, 4'b1111);
      applyStimulus(0, QU, 16'h1150, 0, 0, 0, 0, RES, 16'd0, 6, 4'b1111);
      applyStimulus(0, DE, 0, 0, 0, 0, 16'd0, RES, 16'd0, 2, 4'b1111);
      applyStimulus(0, DE, 0, 0, 0, 0, 16'd99, RES, 16'd0, 6, 4'b1111);
      applyStimulus(0, DE, 0, 0, 0, 0, 16'd2, RES, 16'd0, 6, 4'b1111);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL query[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back;
      rsp_t e, o;
      int   n = 0;
      applyStimulus(0, QU, 16'h4250, 0, 0, 0, 0, OK, 16'd3, 6, 4'b1111);
      testsRun++;
      if (reqReadyA !== 1'b1 || rspValidA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL b2b_ready: ready=%b valid=%b, want 1 1", reqReadyA, rspValidA);
      end
      applyStimulus(0, QU, 16'h5250, 0, 0, 0, 0, OK, 16'd4, 6, 4'b1111);
      repeat (2) @(posedge mclk);
      #1;
      testsRun++;
      if (rspValidA !== 1'b0 || rspStatusA !== OK || rspIdA !== 16'd4) begin
         testsFailed++;
         $display("[TB] FAIL rsp_hold: valid=%b st=%0d id=%h, want 0 0 0004", rspValidA, rspStatusA, rspIdA);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL b2b[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_exhaust;
      rsp_t e, o;
      int   n = 0;
      applyStimulus(1, CR, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, OK, 16'd1, 6, 4'b0001);
      applyStimulus(1, CR, 16'h3000, 16'h3100, 16'h3200, 16'h3300, 0, OK, 16'd2, 6, 4'b0011);
      testsRun++;
      if (idExhB !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL exhaust_early: exh=%b, want 0", idExhB);
      end
      applyStimulus(1, CR, 16'h4000, 16'h4100, 16'h4200, 16'h4300, 0, OK, 16'd3, 6, 4'b0111);
      testsRun++;
      if (idExhB !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL exhaust_set: exh=%b, want 1", idExhB);
      end
      applyStimulus(1, CR, 16'h5000, 16'h5100, 16'h5200, 16'h5300, 0, RES, 16'd0, 2, 4'b0111);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL exhaust[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid;
      rsp_t e, o;
      int   seen = 0;
      int   n = 0;
      @(negedge mclk);
      reqOp = CR; r12 = 16'h8000; r13 = 16'h8100; r14 = 16'h8200; r15 = 16'h8300;
      reqValidA = 1'b1;
      @(posedge mclk);
      #1;
      reqValidA = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      puc_rst = 1'b1;
      repeat (8) begin
         @(posedge mclk);
         #1;
         if (rspValidA) seen++;
      end
      @(negedge mclk);
      puc_rst = 1'b0;
      repeat (3) begin
         @(posedge mclk);
         #1;
         if (rspValidA) seen++;
      end
      testsRun++;
      if (seen != 0 || slotEnA !== 4'b0000 || idExhA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid: pulses=%0d slots=%b exh=%b, want 0 0000 0", seen, slotEnA, idExhA);
      end
      applyStimulus(0, CR, 16'h8000, 16'h8100, 16'h8200, 16'h8300, 0, OK, 16'd1, 6, 4'b0001);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front(); testsRun++;
         if (o.timeout || o.status !== e.status || o.id !== e.id || o.lat != e.lat || o.slots !== e.slots) begin
            testsFailed++;
            $display("[TB] FAIL after_reset[%0d]: got st=%0d id=%h lat=%0d slots=%b to=%0d, want st=%0d id=%h lat=%0d slots=%b",
                     n, o.status, o.id, o.lat, o.slots, o.timeout, e.status, e.id, e.lat, e.slots);
         end
         n++;
      end
   endtask

   task automatic test_prev_pc;
      @(negedge mclk);
      pc = 16'h0010;
      @(negedge mclk);
      pc = 16'h0010;
      @(negedge mclk);
      testsRun++;
      if (prevPcA !== 16'h0000) begin
         testsFailed++;
         $display("[TB] FAIL prev_pc_hold: prev=%h, want 0000", prevPcA);
      end
      pc = 16'h0012;
      @(posedge mclk);
      #1;
      testsRun++;
      if (prevPcA !== 16'h0010) begin
         testsFailed++;
         $display("[TB] FAIL prev_pc_update: prev=%h, want 0010", prevPcA);
      end
      repeat (2) @(posedge mclk);
      #1;
      testsRun++;
      if (prevPcA !== 16'h0010 || prevPcB !== 16'h0010) begin
         testsFailed++;
         $display("[TB] FAIL prev_pc_stable: a=%h b=%h, want 0010 0010", prevPcA, prevPcB);
      end
   endtask

   initial begin
      test_reset;
      test_create;
      test_reject;
      test_fill;
      test_query;
      test_back_to_back;
      test_exhaust;
      test_reset_mid;
      test_prev_pc;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
